// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between the fetch and data ports.
// Data wins by default; a starvation guard forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
   parameter int unsigned LATENCY      = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        dm_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);
   localparam int unsigned   CW    = 4;
   localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
   localparam logic [CW-1:0] LIM_C = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_starve;
   logic          r_sel_dm;
   logic          r_we;
   logic [31:0]   r_if_rdata;
   logic [31:0]   r_dm_rdata;
   logic          r_if_valid;
   logic          r_if_err;
   logic          r_dm_valid;
   logic          r_dm_err;
   logic          r_mem_en;
   logic          r_mem_we;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic          r_busy;

   // Winner selection, only consumed in IDLE
   logic        w_any;
   logic        w_pick_dm;
   logic [31:0] w_addr;
   logic        w_we;
   logic [31:0] w_wdata;
   logic        w_mis;

   assign w_any     = if_req | dm_req;
   assign w_pick_dm = dm_req & ~(if_req & (r_starve == LIM_C));
   assign w_addr    = w_pick_dm ? dm_addr : if_addr;
   assign w_we      = w_pick_dm & dm_we;
   assign w_wdata   = w_pick_dm ? dm_wdata : 32'h0;
   assign w_mis     = (w_addr[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_sel_dm    <= 1'b0;
         r_we        <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_valid  <= 1'b0;
         r_if_err    <= 1'b0;
         r_dm_valid  <= 1'b0;
         r_dm_err    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_sel_dm <= w_pick_dm;
                  r_we     <= w_we;
                  r_busy   <= 1'b1;
                  if (!w_pick_dm) begin
                     r_starve <= '0;
                  end else if (if_req) begin
                     if (r_starve != LIM_C) r_starve <= r_starve + CW'(1);
                  end else begin
                     r_starve <= '0;
                  end
                  // Misaligned accesses complete immediately without touching memory
                  if (w_mis) begin
                     r_state    <= DONE;
                     r_if_valid <= ~w_pick_dm;
                     r_if_err   <= ~w_pick_dm;
                     r_dm_valid <= w_pick_dm;
                     r_dm_err   <= w_pick_dm;
                  end else begin
                     r_state     <= ISSUE;
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= w_we;
                     r_mem_addr  <= {w_addr[31:2], 2'b00};
                     r_mem_wdata <= w_wdata;
                  end
               end else begin
                  r_starve <= '0;
               end
            end
            ISSUE: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_cnt    <= LAT_C;
               r_state  <= WAIT;
            end
            WAIT: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  if (!r_we) begin
                     if (r_sel_dm) r_dm_rdata <= mem_rdata;
                     else          r_if_rdata <= mem_rdata;
                  end
                  r_if_valid <= ~r_sel_dm;
                  r_dm_valid <= r_sel_dm;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               r_if_valid <= 1'b0;
               r_if_err   <= 1'b0;
               r_dm_valid <= 1'b0;
               r_dm_err   <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_rdata  = r_if_rdata;
   assign if_valid  = r_if_valid;
   assign if_err    = r_if_err;
   assign dm_rdata  = r_dm_rdata;
   assign dm_valid  = r_dm_valid;
   assign dm_err    = r_dm_err;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;

endmodule
